// File: rtl/ascon_pack.sv
// Shared constants and types for the ASCON byte packer and its neighbours.
package ascon_pack;

  localparam logic [7:0]  ASCON_PAD_BYTE   = 8'h80;
  localparam int          ASCON_RATE_BYTES = 8;
  localparam logic [63:0] ASCON_PAD_BLOCK  = {ASCON_PAD_BYTE, 56'h0};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2,
    PAD  = 2'd3
  } type_packer_state;

endpackage

// File: rtl/ascon_block_packer.sv
// Packs a plaintext byte stream MSB-first into 64-bit ASCON rate blocks with
// 10* padding, and hands each block downstream over valid/ready.
module ascon_block_packer
  import ascon_pack::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             empty_i,
  input  logic [7:0]       byte_i,
  input  logic             byte_valid_i,
  input  logic             byte_last_i,
  output logic             byte_ready_o,
  output logic [63:0]      block_o,
  output logic             block_valid_o,
  output logic             block_last_o,
  input  logic             block_ready_i,
  output logic [CNT_W-1:0] block_count_o,
  output logic             busy_o
);

  type_packer_state state;
  logic [2:0]       idx;
  logic             pad_pending;
  logic [63:0]      fill_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Register image after accepting byte_i; a short final block also gets its
  // pad byte here. Later bytes are already zero since the register is cleared
  // before each fill.
  always_comb begin
    fill_next = block_o;
    for (int i = 0; i < ASCON_RATE_BYTES; i++) begin
      if (idx == i[2:0]) fill_next[63-8*i -: 8] = byte_i;
      if (byte_last_i && idx != 3'd7 && (idx + 3'd1) == i[2:0])
        fill_next[63-8*i -: 8] = ASCON_PAD_BYTE;
    end
  end

  assign byte_ready_o  = (state == FILL);
  assign block_valid_o = (state == HOLD) || (state == PAD);
  assign busy_o        = (state != IDLE);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state         <= IDLE;
      idx           <= 3'd0;
      pad_pending   <= 1'b0;
      block_o       <= 64'h0;
      block_last_o  <= 1'b0;
      block_count_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            idx           <= 3'd0;
            pad_pending   <= 1'b0;
            block_count_o <= '0;
            block_o       <= empty_i ? ASCON_PAD_BLOCK : 64'h0;
            block_last_o  <= empty_i;
            state         <= empty_i ? PAD : FILL;
          end
        end
        FILL: begin
          if (byte_valid_i) begin
            block_o <= fill_next;
            idx     <= idx + 3'd1;
            if (idx == 3'd7) begin
              state        <= HOLD;
              block_last_o <= 1'b0;
              pad_pending  <= byte_last_i;
            end else if (byte_last_i) begin
              state        <= HOLD;
              block_last_o <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (block_ready_i) begin
            block_count_o <= sat_inc(block_count_o);
            if (block_last_o) begin
              state <= IDLE;
            end else if (pad_pending) begin
              state        <= PAD;
              block_o      <= ASCON_PAD_BLOCK;
              block_last_o <= 1'b1;
              pad_pending  <= 1'b0;
            end else begin
              state   <= FILL;
              block_o <= 64'h0;
            end
          end
        end
        PAD: begin
          if (block_ready_i) begin
            block_count_o <= sat_inc(block_count_o);
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
